ahblite_master_cmd: RTL and testbench
=====================================

Name: ahblite_master_cmd

Overview:
- AHB-lite initiator: turns a simple valid/ready command stream into pipelined AHB-lite single transfers on the master side of the system bus decoder.
- Returns one response per command, in issue order.
- Used by DMA/debug/boot-loader blocks that need bus access without implementing AHB phasing themselves.

Parameters:
- AW, 32, address width (HADDR, cmd_addr)
- DW, 32, data width (HWDATA, HRDATA, cmd_wdata, rsp_rdata)

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- cmd_addr  input  AW  byte address
- cmd_wdata  input  DW  write data
- rsp_valid  output  1  one-cycle response pulse; no backpressure
- rsp_rdata  output  DW  read data; 0 for writes and errors
- rsp_error  output  1  slave ERROR response or misaligned/illegal command
- HADDR  output  AW  address phase
- HTRANS  output  2  IDLE = 2'b00, NONSEQ = 2'b10 only
- HWRITE  output  1
- HSIZE  output  3  {1'b0, cmd_size}
- HWDATA  output  DW  data phase
- HREADY  input  1  bus ready (from decoder mux)
- HRDATA  input  DW  bus read data
- HRESP  input  1  0 = OKAY, 1 = ERROR; tie 0 where the bus carries no HRESP

Behaviour:
- Reset values: HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0. Internal data-phase valid = 0, pending-error = 0.
- Reset asserted mid-transfer: all state clears immediately. The in-flight command produces no response.
- cmd_ready = HREADY (combinational).
  - Address phase registers load only on an edge with HREADY = 1.
  - Load the accepted command if there is one, otherwise HTRANS = IDLE.
  - While HREADY = 0, HADDR/HTRANS/HWRITE/HSIZE are held stable.
- Alignment check at acceptance:
  - Misaligned means half with addr[0] != 0, or word with addr[1:0] != 0, or cmd_size = 3.
  - A misaligned command is accepted but issues HTRANS = IDLE.
  - It is marked pending-error and answered with rsp_error = 1 in its ordered slot; it never touches the bus.
- Data phase:
  - On an HREADY = 1 edge where HTRANS was NONSEQ, latch dp_valid = 1, dp_write, and the write data.
  - HWDATA is driven from the data-phase register and held until the data phase completes.
  - Completion is the first edge with HREADY = 1 while dp_valid. Each cycle with HREADY = 0 is one wait state; there is no limit.
- Response, registered:
  - One cycle after completion: rsp_valid = 1, rsp_error = HRESP, rsp_rdata = HRDATA for reads with no error, else 0.
  - Zero-wait latency is accept edge N → data edge N+1 → rsp_valid high in the cycle after edge N+2.
- ERROR handling:
  - First ERROR cycle (HRESP = 1, HREADY = 0): counted as a wait state; the pending address phase is kept, not cancelled.
  - Second cycle (HRESP = 1, HREADY = 1): completes with rsp_error = 1.
- Ordering:
  - Responses are strictly in command order.
  - A misaligned command following a bus transfer reports one cycle after that transfer's response.
- Back-to-back throughput: one transfer per cycle when HREADY stays high.

Optional Feature:
- Macro AHB_MASTER_PERF_EN.
- Defined: adds outputs perf_xfers (32) and perf_waits (32), plus input perf_clr (1).
  - perf_xfers increments per completed bus transfer.
  - perf_waits increments per data-phase cycle with HREADY = 0.
  - Both saturate at 0xFFFFFFFF.
  - perf_clr zeros both synchronously and takes priority over increments.
  - Both reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Word write 0x20000010 ← 0xA5A5_1234, zero-wait slave → HTRANS NONSEQ one cycle, HWDATA = 0xA5A51234 in the next cycle, rsp_valid with rsp_error = 0 two cycles after accept.
- Read 0x30000000 (unmapped page) → rsp_rdata = 0xDEADBEEF, rsp_error = 0.
- Three back-to-back word reads, slave inserting 2 wait states on the second → address phase held stable during waits, responses in order, cmd_ready low for exactly 2 cycles.
- Slave two-cycle ERROR on a write to 0x48000004 with a read queued behind it → write rsp_error = 1, queued read still completes OKAY.
- Half write to 0x20000001 → no NONSEQ on the bus, rsp_error = 1.
- HRESETn pulsed low during a wait state → HTRANS = IDLE immediately, no rsp_valid, next command works normally.
- With AHB_MASTER_PERF_EN: 4 transfers with 3 total wait states → perf_xfers = 4, perf_waits = 3; perf_clr → both 0.

Source files
------------

// File: rtl/ahblite_master_cmd.sv
// AHB-lite initiator: valid/ready command stream in, pipelined single transfers out, one ordered response per command.
// Optional transfer/wait-state counters are compiled in with `define AHB_MASTER_PERF_EN.
module ahblite_master_cmd #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [1:0]    cmd_size,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA,
  input  logic          HRESP
`ifdef AHB_MASTER_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   perf_xfers,
  output logic [31:0]   perf_waits
`endif
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = lsb[0];
      2'd2:    is_misaligned = |lsb;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  logic          cmd_accept;
  logic          cmd_bad;

  logic [AW-1:0] haddr_q, haddr_d;
  logic          nonseq_q, nonseq_d;
  logic          hwrite_q, hwrite_d;
  logic [1:0]    hsize_q, hsize_d;
  logic [DW-1:0] ap_wdata_q, ap_wdata_d;
  logic          ap_err_q, ap_err_d;

  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic          dp_err_q, dp_err_d;
  logic [DW-1:0] hwdata_q, hwdata_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_error_q, rsp_error_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  assign cmd_ready  = HREADY;
  assign cmd_accept = cmd_valid && HREADY;
  assign cmd_bad    = is_misaligned(cmd_size, cmd_addr[1:0]);

  always_comb begin
    haddr_d     = haddr_q;
    nonseq_d    = nonseq_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    ap_wdata_d  = ap_wdata_q;
    ap_err_d    = ap_err_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_err_d    = dp_err_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    if (HREADY) begin
      // Address phase: a misaligned command takes the slot as IDLE plus a pending error.
      nonseq_d = cmd_accept && !cmd_bad;
      ap_err_d = cmd_accept && cmd_bad;
      if (cmd_accept && !cmd_bad) begin
        haddr_d    = cmd_addr;
        hwrite_d   = cmd_write;
        hsize_d    = cmd_size;
        ap_wdata_d = cmd_wdata;
      end
      // Data phase: pending errors ride the same slot so responses stay in order.
      dp_valid_d = nonseq_q;
      dp_err_d   = ap_err_q;
      if (nonseq_q) begin
        dp_write_d = hwrite_q;
        hwdata_d   = ap_wdata_q;
      end
      // Response: registered on the data-phase completion edge.
      rsp_valid_d = dp_valid_q || dp_err_q;
      rsp_error_d = dp_err_q || (dp_valid_q && HRESP);
      if (dp_valid_q && !dp_write_q && !HRESP) begin
        rsp_rdata_d = HRDATA;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q     <= '0;
      nonseq_q    <= 1'b0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 2'd0;
      ap_wdata_q  <= '0;
      ap_err_q    <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_err_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      haddr_q     <= haddr_d;
      nonseq_q    <= nonseq_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      ap_wdata_q  <= ap_wdata_d;
      ap_err_q    <= ap_err_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_err_q    <= dp_err_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = nonseq_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = {1'b0, hsize_q};
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef AHB_MASTER_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_xfers_q, perf_xfers_d;
  logic [31:0] perf_waits_q, perf_waits_d;

  always_comb begin
    perf_xfers_d = perf_xfers_q;
    perf_waits_d = perf_waits_q;
    if (perf_clr) begin
      perf_xfers_d = '0;
      perf_waits_d = '0;
    end else if (dp_valid_q) begin
      if (HREADY) perf_xfers_d = sat_inc(perf_xfers_q);
      else        perf_waits_d = sat_inc(perf_waits_q);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      perf_xfers_q <= '0;
      perf_waits_q <= '0;
    end else begin
      perf_xfers_q <= perf_xfers_d;
      perf_waits_q <= perf_waits_d;
    end
  end

  assign perf_xfers = perf_xfers_q;
  assign perf_waits = perf_waits_q;
`endif

endmodule

// File: tb/tb_ahblite_master_cmd.sv
// Directed bench for ahblite_master_cmd: behavioural AHB slave, response scoreboard, immediate-assertion checks.
module tb_ahblite_master_cmd;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;
`ifdef AHB_MASTER_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_xfers, perf_waits;
`endif

  always #5 HCLK = ~HCLK;

  ahblite_master_cmd #(.AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
`ifdef AHB_MASTER_PERF_EN
    , .perf_clr(perf_clr), .perf_xfers(perf_xfers), .perf_waits(perf_waits)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   obs_cyc[$];
  int   stamp[$];
  int   cyc = 0;
  int   rdy_low = 0;
  int   hold_viol = 0;
  int   nonseq_cnt = 0;

  // Slave behaviour by address.
  function automatic int waits_for(input logic [31:0] a);
    case (a)
      32'h2000_0104: return 2;
      32'h2000_0400: return 3;
      32'h2000_0604: return 1;
      32'h2000_0608: return 2;
      default:       return 0;
    endcase
  endfunction

  function automatic logic err_for(input logic [31:0] a);
    return a == 32'h4800_0004;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a[31:28] == 4'h3) ? 32'hDEAD_BEEF : (a ^ 32'h1357_9BDF);
  endfunction

  function automatic rsp_t expect_rsp(input logic w, input logic [1:0] sz, input logic [31:0] a);
    rsp_t r;
    logic bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (bad || err_for(a)) r = '{err: 1'b1, rdata: 32'h0};
    else if (w)            r = '{err: 1'b0, rdata: 32'h0};
    else                   r = '{err: 1'b0, rdata: rd_model(a)};
    return r;
  endfunction

  // Slave state, sampled at the active edge (old DUT outputs).
  logic        s_dp = 1'b0, s_write = 1'b0, s_err = 1'b0, s_errph = 1'b0;
  logic [31:0] s_addr = 32'h0;
  int          s_w = 0;

  initial forever begin
    @(posedge HCLK);
    if (!HRESETn) s_dp = 1'b0;
    else if (!HREADY) begin
      if (s_dp) begin
        if (s_err) s_errph = 1'b1;
        else if (s_w > 0) s_w = s_w - 1;
      end
    end else if (HTRANS == 2'b10) begin
      s_dp    = 1'b1;
      s_addr  = HADDR;
      s_write = HWRITE;
      s_err   = err_for(HADDR);
      s_errph = 1'b0;
      s_w     = waits_for(HADDR);
    end else s_dp = 1'b0;
  end

  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      HRDATA = 32'hBAD0_BAD0;
      if (!s_dp) begin
        HREADY = 1'b1; HRESP = 1'b0;
      end else if (s_err) begin
        HREADY = s_errph; HRESP = 1'b1;
      end else if (s_w > 0) begin
        HREADY = 1'b0; HRESP = 1'b0;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
        if (!s_write) HRDATA = rd_model(s_addr);
      end
    end
  end

  initial forever begin
    @(posedge HCLK);
    cyc = cyc + 1;
  end

  // Bus/response monitor.
  logic        r_wait = 1'b0;
  logic [37:0] prev_ap = '0;
  initial forever begin
    @(negedge HCLK);
    if (HRESETn) begin
      if (r_wait && {HADDR, HTRANS, HWRITE, HSIZE} != prev_ap) hold_viol = hold_viol + 1;
      if (!cmd_ready) rdy_low = rdy_low + 1;
      if (HTRANS == 2'b10) nonseq_cnt = nonseq_cnt + 1;
      if (rsp_valid) begin
        obs_q.push_back({rsp_error, rsp_rdata});
        obs_cyc.push_back(cyc);
      end
    end
    prev_ap = {HADDR, HTRANS, HWRITE, HSIZE};
    @(posedge HCLK);
    r_wait = HRESETn && !HREADY;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
    do begin
      @(posedge HCLK);
      n++;
    end while (!cmd_ready && n < 50);
    chk("accept", 64'(cmd_ready), 64'(1));
    exp_q.push_back(expect_rsp(w, sz, a));
  endtask

  task automatic cmd_off();
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int   n;
    rsp_t e, o;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    repeat (3) @(negedge HCLK);
    stamp.delete();
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      stamp.push_back(obs_cyc.pop_front());
      chk(tag, 64'(o), 64'(e));
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required<20000", cyc);
    $fatal(1, "watchdog expired");
  end

  int a0, r0, h0, n0;

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
`ifdef AHB_MASTER_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", 64'(HTRANS), 64'(0));
    chk("rst_haddr", 64'(HADDR), 64'(0));
    chk("rst_hwrite", 64'(HWRITE), 64'(0));
    chk("rst_hsize", 64'(HSIZE), 64'(0));
    chk("rst_hwdata", 64'(HWDATA), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error), 64'(0));
    HRESETn = 1'b1;

    // Zero-wait word write: phase timing and latency.
    send_cmd(1'b1, 2'd2, 32'h2000_0010, 32'hA5A5_1234);
    cmd_off();
    a0 = cyc;
    chk("wr_htrans", 64'(HTRANS), 64'(2'b10));
    chk("wr_haddr", 64'(HADDR), 64'(32'h2000_0010));
    chk("wr_hwrite", 64'(HWRITE), 64'(1));
    chk("wr_hsize", 64'(HSIZE), 64'(3'd2));
    @(negedge HCLK);
    chk("wr_htrans_idle", 64'(HTRANS), 64'(0));
    chk("wr_hwdata", 64'(HWDATA), 64'(32'hA5A5_1234));
    chk("wr_rsp_early", 64'(rsp_valid), 64'(0));
    @(negedge HCLK);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wr_rsp_error", 64'(rsp_error), 64'(0));
    drain("wr");
    chk("wr_latency", 64'(stamp[0] - a0), 64'(2));

    // Unmapped-page read.
    send_cmd(1'b0, 2'd2, 32'h3000_0000, 32'h0);
    cmd_off();
    drain("rd_unmapped");

    // Back-to-back reads with two wait states on the second.
    r0 = rdy_low; h0 = hold_viol;
    send_cmd(1'b0, 2'd2, 32'h2000_0100, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_0104, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_0108, 32'h0);
    cmd_off();
    drain("b2b");
    chk("b2b_ready_low", 64'(rdy_low - r0), 64'(2));
    chk("b2b_hold", 64'(hold_viol - h0), 64'(0));
    chk("b2b_gap1", 64'(stamp[1] - stamp[0]), 64'(3));
    chk("b2b_gap2", 64'(stamp[2] - stamp[1]), 64'(1));

    // Two-cycle ERROR on write with a read queued, then an erroring read.
    h0 = hold_viol;
    send_cmd(1'b1, 2'd2, 32'h4800_0004, 32'h1111_2222);
    send_cmd(1'b0, 2'd2, 32'h2000_0200, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h4800_0004, 32'h0);
    cmd_off();
    drain("err");
    chk("err_hold", 64'(hold_viol - h0), 64'(0));

    // Misaligned half write never reaches the bus.
    n0 = nonseq_cnt;
    send_cmd(1'b1, 2'd1, 32'h2000_0001, 32'h0000_0055);
    cmd_off();
    drain("mis_half");
    chk("mis_no_nonseq", 64'(nonseq_cnt - n0), 64'(0));

    // Error-only commands keep their ordered slot behind a bus read.
    send_cmd(1'b0, 2'd2, 32'h2000_0300, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_0302, 32'h0);
    send_cmd(1'b1, 2'd3, 32'h2000_0700, 32'h0);
    cmd_off();
    drain("order");
    chk("order_gap1", 64'(stamp[1] - stamp[0]), 64'(1));
    chk("order_gap2", 64'(stamp[2] - stamp[1]), 64'(1));

    // Legal sub-word accesses.
    send_cmd(1'b0, 2'd1, 32'h2000_0802, 32'h0);
    cmd_off();
    chk("half_hsize", 64'(HSIZE), 64'(3'd1));
    send_cmd(1'b0, 2'd0, 32'h2000_0803, 32'h0);
    cmd_off();
    drain("sub");

    // Reset pulsed during a wait state with another command in address phase.
    send_cmd(1'b0, 2'd2, 32'h2000_0400, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_0404, 32'h0);
    cmd_off();
    @(negedge HCLK);
    chk("rstw_pre_htrans", 64'(HTRANS), 64'(2'b10));
    chk("rstw_pre_hready", 64'(HREADY), 64'(0));
    #2 HRESETn = 1'b0;
    #1;
    chk("rstw_htrans", 64'(HTRANS), 64'(0));
    chk("rstw_haddr", 64'(HADDR), 64'(0));
    chk("rstw_rsp", 64'(rsp_valid), 64'(0));
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);
    chk("rstw_no_rsp", 64'(obs_q.size()), 64'(0));
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    send_cmd(1'b1, 2'd2, 32'h2000_0500, 32'h0BAD_F00D);
    send_cmd(1'b0, 2'd2, 32'h2000_0504, 32'h0);
    cmd_off();
    drain("post_rst");

`ifdef AHB_MASTER_PERF_EN
    @(negedge HCLK); perf_clr = 1'b1;
    @(negedge HCLK); perf_clr = 1'b0;
    send_cmd(1'b0, 2'd2, 32'h2000_0600, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_0604, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_0608, 32'h0);
    send_cmd(1'b0, 2'd2, 32'h2000_060C, 32'h0);
    cmd_off();
    drain("perf_rd");
    chk("perf_xfers", 64'(perf_xfers), 64'(4));
    chk("perf_waits", 64'(perf_waits), 64'(3));
    @(negedge HCLK); perf_clr = 1'b1;
    @(negedge HCLK); perf_clr = 1'b0;
    chk("perf_clr_xfers", 64'(perf_xfers), 64'(0));
    chk("perf_clr_waits", 64'(perf_waits), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
